// File: rtl/control_sequencer_if.sv
// control_sequencer_if: decoder inputs and control-word outputs of the sequencer.
interface control_sequencer_if;
   logic [3:0]  opcode;
   logic        zero_flag;
   logic        mem_ready;
   logic [15:0] control;
   logic [2:0]  state_o;
   logic        instr_done;
   modport master (output opcode, zero_flag, mem_ready, input control, state_o, instr_done);
   modport slave  (input opcode, zero_flag, mem_ready, output control, state_o, instr_done);
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute FSM producing the datapath control word.
module control_sequencer (
   input  logic                clk,
   input  logic                rst_n,
   control_sequencer_if.slave  bus
);
   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, HALT = 3'd4;
   localparam logic [15:0] PC_INC = 16'h0001, PC_LOAD = 16'h0002, IR_LOAD = 16'h0004,
                           MEM_RD = 16'h0008, MEM_WR = 16'h0010, M1_IMM = 16'h0020,
                           M1_ALU = 16'h0040, ACC_LD_A = 16'h0080, ACC_LD_SH = 16'h0100,
                           SH_RIGHT = 16'h0200, ALU_SUB = 16'h0400, FLAG_LD = 16'h0800,
                           B_LD = 16'h1000, OUT_LD = 16'h2000, HALTED = 16'h4000,
                           ADDR_SEL = 16'h8000;
   logic [2:0]  state_q, state_d;
   logic [15:0] exec_word, control;
   logic        mem_op;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   assign mem_op = bus.opcode == 4'h2 || bus.opcode == 4'h3;
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
         DECODE:  state_d = bus.opcode == 4'hF ? HALT : EXEC;
         EXEC:    state_d = mem_op && !bus.mem_ready ? EXEC : FETCH;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end
   // Each opcode's word sets at most one accumulator-load source.
   always_comb begin
      exec_word = '0;
      case (bus.opcode)
         4'h1: exec_word = M1_IMM | ACC_LD_A | FLAG_LD;
         4'h2: exec_word = MEM_RD | ADDR_SEL | (bus.mem_ready ? ACC_LD_A | FLAG_LD : 16'h0);
         4'h3: exec_word = MEM_WR | ADDR_SEL;
         4'h4: exec_word = M1_ALU | ACC_LD_A | FLAG_LD;
         4'h5: exec_word = M1_ALU | ALU_SUB | ACC_LD_A | FLAG_LD;
         4'h6: exec_word = ACC_LD_SH | FLAG_LD;
         4'h7: exec_word = ACC_LD_SH | SH_RIGHT | FLAG_LD;
         4'h8: exec_word = PC_LOAD;
         4'h9: exec_word = bus.zero_flag ? PC_LOAD : 16'h0;
         4'hA: exec_word = M1_IMM | B_LD;
         4'hB: exec_word = OUT_LD;
         default: exec_word = '0;
      endcase
   end
   always_comb begin
      control = '0;
      case (state_q)
         FETCH:   control = MEM_RD | (bus.mem_ready ? IR_LOAD | PC_INC : 16'h0);
         EXEC:    control = exec_word;
         HALT:    control = HALTED;
         default: control = '0;
      endcase
   end
   assign bus.control    = control;
   assign bus.state_o    = state_q;
   assign bus.instr_done = (state_q == EXEC && state_d == FETCH) || (state_q == DECODE && state_d == HALT);
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: transaction-level trace model checked against the sequencer every cycle.
module tb_control_sequencer;
   typedef struct {
      logic [2:0]  st;
      logic        rdy;
      logic [3:0]  op;
      logic        z;
      logic [15:0] ctl;
      logic        done;
   } ent_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic chk_en = 1'b0;
   int checks = 0;
   int errors = 0;
   ent_t q[$];
   ent_t cur;
   control_sequencer_if bus ();
   control_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   function automatic logic [15:0] b(int n);
      return 16'h1 << n;
   endfunction
   // Instruction table written from the bit list, independent of the design's masks.
   function automatic logic [15:0] exec_word(logic [3:0] op, logic rdy, logic z);
      case (op)
         4'h1: return b(5) | b(7) | b(11);
         4'h2: return b(3) | b(15) | (rdy ? b(7) | b(11) : 16'h0);
         4'h3: return b(4) | b(15);
         4'h4: return b(6) | b(7) | b(11);
         4'h5: return b(6) | b(10) | b(7) | b(11);
         4'h6: return b(8) | b(11);
         4'h7: return b(8) | b(9) | b(11);
         4'h8: return b(1);
         4'h9: return z ? b(1) : 16'h0;
         4'hA: return b(5) | b(12);
         4'hB: return b(13);
         default: return 16'h0;
      endcase
   endfunction
   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask
   task automatic push(logic [2:0] st, logic rdy, logic [3:0] op, logic z, logic [15:0] ctl, logic done);
      ent_t e;
      e.st = st; e.rdy = rdy; e.op = op; e.z = z; e.ctl = ctl; e.done = done;
      q.push_back(e);
   endtask
   task automatic add_instr(logic [3:0] op, int nf, int ne);
      logic z;
      for (int i = 0; i < nf; i++) push(1, 0, 4'($urandom), 1'($urandom), b(3), 0);
      push(1, 1, 4'($urandom), 1'($urandom), b(3) | b(2) | b(0), 0);
      push(2, 1'($urandom), op, 1'($urandom), 16'h0, op == 4'hF);
      if (op == 4'hF) return;
      if (op == 4'h2 || op == 4'h3) begin
         for (int i = 0; i < ne; i++) begin
            z = 1'($urandom);
            push(3, 0, op, z, exec_word(op, 0, z), 0);
         end
         z = 1'($urandom);
         push(3, 1, op, z, exec_word(op, 1, z), 1);
      end else begin
         z = 1'($urandom);
         push(3, 1'($urandom), op, z, exec_word(op, 0, z), 1);
      end
   endtask
   task automatic run();
      while (q.size() > 0) begin
         cur = q.pop_front();
         bus.mem_ready = cur.rdy;
         bus.opcode = cur.op;
         bus.zero_flag = cur.z;
         chk_en = 1'b1;
         @(posedge clk);
         #1;
      end
      chk_en = 1'b0;
   endtask
   task automatic do_reset();
      chk_en = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
   always @(negedge clk) if (chk_en) begin
      chk("state_o", 16'(bus.state_o), 16'(cur.st));
      chk("control", bus.control, cur.ctl);
      chk("instr_done", 16'(bus.instr_done), 16'(cur.done));
      chk("acc_excl", 16'(bus.control[7] & bus.control[8]), 16'h0);
      chk("mem_excl", 16'(bus.control[3] & bus.control[4]), 16'h0);
      chk("pc_excl", 16'(bus.control[0] & bus.control[1]), 16'h0);
      chk("m1_sel", 16'(bus.control[6] & bus.control[5]), 16'h0);
   end
   initial begin
      bus.opcode = 4'h0;
      bus.zero_flag = 1'b0;
      bus.mem_ready = 1'b1;
      chk("model_add", exec_word(4'h4, 1, 0), 16'h08C0);
      chk("model_sub", exec_word(4'h5, 1, 0), 16'h0CC0);
      chk("model_shl", exec_word(4'h6, 1, 0), 16'h0900);
      chk("model_shr", exec_word(4'h7, 1, 0), 16'h0B00);
      chk("model_jz0", exec_word(4'h9, 1, 0), 16'h0000);
      chk("model_jz1", exec_word(4'h9, 1, 1), 16'h0002);
      chk("model_jmp", exec_word(4'h8, 1, 0), 16'h0002);
      chk("model_lda", exec_word(4'h2, 1, 0), 16'h8888);
      #2;
      do_reset();
      push(0, 1, 1, 0, 16'h0000, 0);
      push(1, 1, 1, 0, 16'h000D, 0);
      push(2, 1, 1, 0, 16'h0000, 0);
      push(3, 1, 1, 0, 16'h08A0, 1);
      push(1, 0, 2, 0, 16'h0008, 0);
      push(1, 0, 2, 0, 16'h0008, 0);
      push(1, 1, 2, 0, 16'h000D, 0);
      push(2, 0, 2, 0, 16'h0000, 0);
      push(3, 0, 2, 0, 16'h8008, 0);
      push(3, 0, 2, 1, 16'h8008, 0);
      push(3, 0, 2, 0, 16'h8008, 0);
      push(3, 1, 2, 0, 16'h8888, 1);
      for (int op = 4; op < 8; op++) add_instr(4'(op), 0, 0);
      add_instr(4'h9, 0, 0);
      add_instr(4'h8, 1, 0);
      for (int i = 0; i < 80; i++) add_instr(4'($urandom_range(0, 14)), $urandom_range(0, 3), $urandom_range(0, 3));
      add_instr(4'hF, 1, 0);
      for (int i = 0; i < 20; i++) push(4, 1'($urandom), 4'($urandom), 1'($urandom), 16'h4000, 0);
      run();
      do_reset();
      push(0, 1, 3, 0, 16'h0000, 0);
      add_instr(4'h3, 0, 4);
      void'(q.pop_back());
      run();
      bus.mem_ready = 1'b0;
      bus.opcode = 4'h3;
      #1;
      chk("sta_wait", bus.control, 16'h8010);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_control", bus.control, 16'h0000);
      chk("rst_state", 16'(bus.state_o), 16'h0);
      chk("rst_done", 16'(bus.instr_done), 16'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      push(0, 1, 3, 0, 16'h0000, 0);
      push(1, 1, 3, 0, 16'h000D, 0);
      run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
